// File: rtl/eth_parser_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_parser_ctrl_pkg
// Description : Shared types, constants and helpers for the ethernet parser
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_parser_ctrl_pkg;

    localparam int c_CTRL_WIDTH = 8;
    localparam int c_IDLE_CTRL  = 0;
    localparam int c_CNT_WIDTH  = 8;

    typedef enum logic [0:0] {
        ST_HDR     = 1'b0,
        ST_PAYLOAD = 1'b1
    } pkt_state_t;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // One request-register cycle on top of the NUM_QUEUES/2+1 search cycles.
    function automatic int search_cycles(input int num_queues);
        return num_queues / 2 + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_parser_ctrl_pkt_word_tracker.sv
`default_nettype none
// ============================================================================
// Module      : eth_parser_ctrl_pkt_word_tracker
// Description : Follows packet framing on the input bus and reports the
//               payload word index of the word currently on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_parser_ctrl_pkt_word_tracker
    import eth_parser_ctrl_pkg::*;
#(
    parameter int CTRL_WIDTH = c_CTRL_WIDTH,
    parameter int CNT_WIDTH  = c_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic [CNT_WIDTH-1:0]  word_idx,
    output logic                  in_hdr
);

    pkt_state_t           r_state;
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic                 w_ctrl_idle;

    assign w_ctrl_idle = (in_ctrl == CTRL_WIDTH'(c_IDLE_CTRL));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_HDR;
            r_word_cnt <= '0;
        end else if (in_wr) begin
            if (!w_ctrl_idle) begin
                r_state    <= ST_HDR;
                r_word_cnt <= '0;
            end else if (r_state == ST_HDR) begin
                r_state    <= ST_PAYLOAD;
                r_word_cnt <= CNT_WIDTH'(1);
            end else if (r_word_cnt != '1) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign in_hdr   = (r_state == ST_HDR);
    assign word_idx = in_hdr ? '0 : r_word_cnt;

endmodule
`default_nettype wire

// File: rtl/eth_parser_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eth_parser_ctrl
// Description : MAC/ethertype parser sequencer: header strobes, upstream
//               throttling during MAC search and parser info FIFO pops.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_parser_ctrl
    import eth_parser_ctrl_pkg::*;
#(
    parameter int CTRL_WIDTH      = c_CTRL_WIDTH,
    parameter int NUM_QUEUES      = 8,
    parameter int DA_HI_WORD      = 0,
    parameter int DASA_WORD       = 0,
    parameter int ETH_IP_VER_WORD = 1,
    parameter int INFO_DEPTH      = 4,
    parameter int SEARCH_CYCLES   = search_cycles(NUM_QUEUES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CTRL_WIDTH-1:0]         in_ctrl,
    input  logic                          in_wr,
    input  logic                          out_rdy,
    output logic                          in_rdy,
    output logic                          word_MAC_DA_HI,
    output logic                          word_MAC_DASA,
    output logic                          word_ETH_IP_VER,
    input  logic                          eth_parser_info_vld,
    output logic                          eth_parser_rd_info,
    input  logic                          proc_pkt_done,
    output logic [clog2(INFO_DEPTH):0]    info_occupancy,
    output logic                          underflow_err
);

    localparam int c_OCC_W   = clog2(INFO_DEPTH) + 1;
    localparam int c_GUARD_W = clog2(SEARCH_CYCLES + 1);

    logic [c_CNT_WIDTH-1:0] w_word_idx;
    logic                   w_in_hdr;
    logic                   w_payload;
    logic                   w_stall;

    logic [c_GUARD_W-1:0]   r_guard;
    logic [c_OCC_W-1:0]     r_occ;
    logic                   r_rd_info;
    logic                   r_underflow;
    logic                   r_live;

    eth_parser_ctrl_pkt_word_tracker #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .CNT_WIDTH  (c_CNT_WIDTH)
    ) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .word_idx (w_word_idx),
        .in_hdr   (w_in_hdr)
    );

    // Strobes are forced low while reset is held even if the bus is active.
    assign w_payload       = reset && in_wr && (in_ctrl == CTRL_WIDTH'(c_IDLE_CTRL));
    assign word_MAC_DA_HI  = w_payload && (w_word_idx == c_CNT_WIDTH'(DA_HI_WORD));
    assign word_MAC_DASA   = w_payload && (w_word_idx == c_CNT_WIDTH'(DASA_WORD));
    assign word_ETH_IP_VER = w_payload && (w_word_idx == c_CNT_WIDTH'(ETH_IP_VER_WORD));

    assign w_stall = w_in_hdr && ((r_guard != '0) || (r_occ == c_OCC_W'(INFO_DEPTH)));
    assign in_rdy  = r_live && out_rdy && !w_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live      <= 1'b0;
            r_guard     <= '0;
            r_occ       <= '0;
            r_rd_info   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_live <= 1'b1;

            if (word_ETH_IP_VER) begin
                r_guard <= c_GUARD_W'(SEARCH_CYCLES);
            end else if (r_guard != '0) begin
                r_guard <= r_guard - 1'b1;
            end

            case ({word_ETH_IP_VER, r_rd_info})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   if (r_occ != '0) r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase

            r_rd_info <= proc_pkt_done && eth_parser_info_vld;
            if (proc_pkt_done && !eth_parser_info_vld) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign eth_parser_rd_info = r_rd_info;
    assign info_occupancy     = r_occ;
    assign underflow_err      = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_eth_parser_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_parser_ctrl
// Description : Self-checking bench for eth_parser_ctrl against a cycle-level
//               behavioural model of packet framing, guard and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_parser_ctrl;

    localparam int SEARCH = 6;
    localparam int DEPTH  = 4;
    localparam int DAHW   = 0;
    localparam int DASAW  = 0;
    localparam int ETHW   = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_ctrl = 8'h00;
    logic       in_wr = 1'b0;
    logic       out_rdy = 1'b0;
    logic       info_vld = 1'b0;
    logic       done = 1'b0;
    logic       in_rdy, da_hi, dasa, eth_ver, rd_info, ufl;
    logic [2:0] occ;

    eth_parser_ctrl #(
        .CTRL_WIDTH      (8),
        .NUM_QUEUES      (8),
        .DA_HI_WORD      (DAHW),
        .DASA_WORD       (DASAW),
        .ETH_IP_VER_WORD (ETHW),
        .INFO_DEPTH      (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_ctrl             (in_ctrl),
        .in_wr               (in_wr),
        .out_rdy             (out_rdy),
        .in_rdy              (in_rdy),
        .word_MAC_DA_HI      (da_hi),
        .word_MAC_DASA       (dasa),
        .word_ETH_IP_VER     (eth_ver),
        .eth_parser_info_vld (info_vld),
        .eth_parser_rd_info  (rd_info),
        .proc_pkt_done       (done),
        .info_occupancy      (occ),
        .underflow_err       (ufl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tcyc     = 0;

    always @(posedge clk) tcyc <= tcyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: m_pos = payload words seen in the current packet (0 = between
    // packets), m_acc = outstanding info results, m_last_eth = cycle of the
    // most recent ethertype word, m_c = cycles since reset release.
    int   m_c = 0, m_pos = 0, m_last_eth = -100, m_acc = 0;
    logic m_prev_ok = 1'b0, m_ufl = 1'b0;

    always @(negedge clk) begin
        logic pay, e_da, e_dasa, e_eth, guard_on, stall, e_rdy;
        if (!reset) begin
            chk("reset_outputs", {in_rdy, da_hi, dasa, eth_ver, rd_info, ufl, occ}, 0);
            m_c = 0; m_pos = 0; m_last_eth = -100; m_acc = 0;
            m_prev_ok = 1'b0; m_ufl = 1'b0;
        end else begin
            pay      = in_wr && (in_ctrl == 8'h00);
            e_da     = pay && (m_pos == DAHW);
            e_dasa   = pay && (m_pos == DASAW);
            e_eth    = pay && (m_pos == ETHW);
            guard_on = ((m_c - m_last_eth) >= 1) && ((m_c - m_last_eth) <= SEARCH);
            stall    = (m_pos == 0) && (guard_on || (m_acc == DEPTH));
            e_rdy    = out_rdy && !stall && (m_c >= 1);
            chk("strobes", {da_hi, dasa, eth_ver}, {e_da, e_dasa, e_eth});
            chk("in_rdy", in_rdy, e_rdy);
            chk("rd_info", rd_info, m_prev_ok);
            chk("occupancy", occ, m_acc);
            chk("underflow", ufl, m_ufl);
            m_acc = m_acc + (e_eth ? 1 : 0) - (m_prev_ok ? 1 : 0);
            if (e_eth) m_last_eth = m_c;
            m_prev_ok = done && info_vld;
            if (done && !info_vld) m_ufl = 1'b1;
            if (in_wr) m_pos = (in_ctrl != 8'h00) ? 0 : m_pos + 1;
            m_c++;
        end
    end

    logic done_req = 1'b0, done_vld = 1'b1, rand_rdy = 1'b0, auto_done = 1'b0;
    int   last_done = -100;

    task automatic step(input logic want, input logic [7:0] ctrl, output logic acc);
        @(posedge clk);
        #1;
        done     = 1'b0;
        info_vld = (m_acc > 0);
        if (auto_done && !done_req && m_acc > 0 && (tcyc - last_done) >= 3
            && $urandom_range(0, 3) == 0) begin
            done_req = 1'b1;
        end
        if (done_req) begin
            done      = 1'b1;
            info_vld  = done_vld;
            done_req  = 1'b0;
            last_done = tcyc;
        end
        out_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_ctrl = ctrl;
        in_wr   = 1'b0;
        #1;
        if (want && in_rdy) in_wr = 1'b1;
        acc = in_wr;
    endtask

    task automatic send(input logic [7:0] ctrl);
        logic acc;
        int   t = 0;
        do begin
            step(1'b1, ctrl, acc);
            t++;
        end while (!acc && t < 60);
        chk("send_accepted", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) step(1'b0, 8'h00, acc);
    endtask

    task automatic send_pkt(input int nhdr, input int npay);
        repeat (nhdr) send(8'hFF);
        for (int i = 0; i < npay; i++) send(8'h00);
        send(8'h40);
    endtask

    int t_eth, t_hdr;

    initial begin
        #1 reset = 1'b0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #3;
        chk("rdy_after_reset", in_rdy, 1'b1);
        chk("occ_after_reset", occ, 3'd0);

        // Packet 1: header, 8 payload words, last word.
        send(8'hFF);
        send(8'h00); #2 chk("pkt1_word0_strobes", {da_hi, dasa, eth_ver}, 3'b110);
        send(8'h00); #2 chk("pkt1_word1_strobes", {da_hi, dasa, eth_ver}, 3'b001);
        idle(1);     #2 chk("pkt1_occ", occ, 3'd1);
        for (int i = 0; i < 6; i++) send(8'h00);
        send(8'h40);

        // Packet 2 ends right after its ethertype; next header waits on guard.
        send(8'hFF);
        send(8'h00);
        send(8'h00); t_eth = tcyc;
        send(8'h40);
        send(8'hFF); t_hdr = tcyc;
        chk("guard_release_cycles", t_hdr - t_eth, SEARCH + 1);
        send_pkt(0, 3);
        send_pkt(1, 3);

        // Four results outstanding: headers are held off.
        idle(10);
        #2 chk("full_occ", occ, 3'd4);
        chk("full_in_rdy", in_rdy, 1'b0);
        done_req = 1'b1; done_vld = 1'b1;
        idle(1);
        idle(1); #2 chk("pop_rd_info", rd_info, 1'b1);
        idle(1); #2 chk("pop_rd_info_single", rd_info, 1'b0);
        chk("pop_occ", occ, 3'd3);
        chk("pop_in_rdy", in_rdy, 1'b1);

        // Pop lands in the same cycle as the ethertype increment.
        send(8'hFF);
        done_req = 1'b1;
        send(8'h00);
        send(8'h00); #2 chk("same_cycle_rd_info", rd_info, 1'b1);
        send(8'h40); #2 chk("same_cycle_occ", occ, 3'd3);

        // Done with no info valid.
        idle(8);
        done_req = 1'b1; done_vld = 1'b0;
        idle(1);
        idle(1); #2 chk("underflow_set", ufl, 1'b1);
        chk("underflow_no_pop", rd_info, 1'b0);
        idle(5); #2 chk("underflow_sticky", ufl, 1'b1);
        done_vld = 1'b1;
        repeat (3) begin
            done_req = 1'b1;
            idle(3);
        end
        #2 chk("drained_occ", occ, 3'd0);

        // Runt packet.
        send(8'hFF);
        send(8'h00); #2 chk("runt_strobes", {da_hi, dasa, eth_ver}, 3'b110);
        send(8'h40);
        idle(1); #2 chk("runt_occ", occ, 3'd0);
        chk("runt_no_guard", in_rdy, 1'b1);

        // Reset asserted in the middle of a payload.
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        @(posedge clk);
        #1 reset = 1'b0; in_wr = 1'b0; done = 1'b0;
        #2 chk("async_reset_occ", occ, 3'd0);
        chk("async_reset_rdy", in_rdy, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(1);
        send(8'h00); #2 chk("post_reset_word0", {da_hi, dasa, eth_ver}, 3'b110);
        send(8'h40);

        // Randomized traffic.
        rand_rdy  = 1'b1;
        auto_done = 1'b1;
        repeat (60) begin
            idle($urandom_range(0, 3));
            send_pkt($urandom_range(0, 2), $urandom_range(1, 5));
        end
        auto_done = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
